// File: rtl/addsub_seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_seg7_scan_if
// Description : Result/display bus between the add/sub unit, the display
//               scan stage and the 7-segment pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_seg7_scan_if;
  logic       load;
  logic [3:0] sum;
  logic       ovf;
  logic       sel;
  logic [6:0] seg;
  logic [3:0] an;

  // Producer side: drives the result capture signals, observes the pins
  modport master (output load, sum, ovf, sel, input seg, an);
  // Display stage side
  modport slave  (input load, sum, ovf, sel, output seg, an);
endinterface
`default_nettype wire

// File: rtl/addsub_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : addsub_seg7_scan
// Description : Captures a 4-bit signed add/sub result and shows op glyph,
//               sign and magnitude (or "OF") on a 4-digit multiplexed
//               common-anode 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_seg7_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_seg7_scan_if.slave   bus
);

  localparam int          c_CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(REFRESH_DIV - 1);

  localparam logic [6:0] c_BLANK = 7'h7F;
  localparam logic [6:0] c_MINUS = 7'h3F;
  localparam logic [6:0] c_GLY_A = 7'h08;
  localparam logic [6:0] c_GLY_D = 7'h21;
  localparam logic [6:0] c_GLY_O = 7'h40;
  localparam logic [6:0] c_GLY_F = 7'h0E;

  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_idx;
  logic [3:0]      r_sum;
  logic            r_ovf;
  logic            r_sel;
  logic            r_valid;
  logic [6:0]      r_seg;
  logic [3:0]      r_an;

  logic [3:0]      w_mag;
  logic [6:0]      w_digit;
  logic [6:0]      w_seg;
  logic [3:0]      w_an;

  // Free-running prescaler; digit index advances on each wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Level-sampled capture of the add/sub result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= 4'd0;
      r_ovf   <= 1'b0;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.load) begin
      r_sum   <= bus.sum;
      r_ovf   <= bus.ovf;
      r_sel   <= bus.sel;
      r_valid <= 1'b1;
    end
  end

  // Magnitude is taken 4 bits wide so -8 wraps to 4'b1000 and reads as 8
  assign w_mag = r_sum[3] ? (~r_sum + 4'd1) : r_sum;

  // Decimal glyph for the magnitude; values above 8 cannot arise
  always_comb begin
    w_digit = c_BLANK;
    case (w_mag)
      4'd0:    w_digit = 7'h40;
      4'd1:    w_digit = 7'h79;
      4'd2:    w_digit = 7'h24;
      4'd3:    w_digit = 7'h30;
      4'd4:    w_digit = 7'h19;
      4'd5:    w_digit = 7'h12;
      4'd6:    w_digit = 7'h02;
      4'd7:    w_digit = 7'h78;
      4'd8:    w_digit = 7'h00;
      default: w_digit = c_BLANK;
    endcase
  end

  // Select slot content and anode for the current digit index
  always_comb begin
    w_seg = c_BLANK;
    w_an  = 4'hF;
    if (r_valid) begin
      w_an = ~(4'b0001 << r_idx);
      case (r_idx)
        2'd3:    w_seg = r_sel ? c_GLY_D : c_GLY_A;
        2'd2:    w_seg = c_BLANK;
        2'd1:    w_seg = r_ovf ? c_GLY_O : (r_sum[3] ? c_MINUS : c_BLANK);
        default: w_seg = r_ovf ? c_GLY_F : w_digit;
      endcase
    end
  end

  // Registered pins: no combinational path from inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= c_BLANK;
      r_an  <= 4'hF;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_seg7_scan
// Description : Directed, table-driven bench for addsub_seg7_scan with
//               REFRESH_DIV = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_seg7_scan;

  localparam int c_DIV = 4;

  typedef struct {
    logic [3:0] sum;
    logic       ovf;
    logic       sel;
    logic [6:0] exp_seg [4];
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_edges;
  int   n_checks;
  int   n_fail;
  logic       exp_valid;
  logic [6:0] cur_exp [4];
  vec_t       vecs [8];

  addsub_seg7_scan_if bus_if ();

  addsub_seg7_scan #(.REFRESH_DIV(c_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset edge; pins after edge n show slot ((n-1)/DIV)%4
  always @(posedge clk) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  function automatic int pin_slot();
    return ((n_edges - 1) / c_DIV) % 4;
  endfunction

  function automatic int slot_ofs();
    return (n_edges - 1) % c_DIV;
  endfunction

  task automatic check_pins(input string nm);
    logic [6:0] es;
    logic [3:0] ea;
    int s;
    s  = pin_slot();
    es = exp_valid ? cur_exp[s] : 7'h7F;
    ea = exp_valid ? ~(4'b0001 << s) : 4'hF;
    n_checks++;
    if (bus_if.seg !== es) begin
      n_fail++;
      $display("FAIL %s seg slot %0d: got %h expected %h", nm, s, bus_if.seg, es);
    end
    n_checks++;
    if (bus_if.an !== ea) begin
      n_fail++;
      $display("FAIL %s an slot %0d: got %h expected %h", nm, s, bus_if.an, ea);
    end
  endtask

  task automatic set_exp(input vec_t v);
    for (int i = 0; i < 4; i++) cur_exp[i] = v.exp_seg[i];
  endtask

  // Load one record for one cycle, then check the following 16 cycles
  task automatic load_and_scan(input vec_t v, input string nm);
    bus_if.load = 1'b1;
    bus_if.sum  = v.sum;
    bus_if.ovf  = v.ovf;
    bus_if.sel  = v.sel;
    @(negedge clk);
    bus_if.load = 1'b0;
    exp_valid   = 1'b1;
    set_exp(v);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check_pins(nm);
    end
  endtask

  // Bounded wait for a given pin slot and offset within the slot
  task automatic wait_slot(input int s, input int ofs, input string nm);
    int k;
    k = 0;
    while (!(pin_slot() == s && slot_ofs() == ofs) && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 40) begin
      n_fail++;
      $display("FAIL %s wait: got timeout expected slot %0d", nm, s);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_valid = 1'b0;
    for (int i = 0; i < 4; i++) cur_exp[i] = 7'h7F;

    // {sum, ovf, sel, {idx0, idx1, idx2, idx3}}
    vecs[0] = '{4'b0011, 1'b0, 1'b0, '{7'h30, 7'h7F, 7'h7F, 7'h08}};
    vecs[1] = '{4'b1000, 1'b0, 1'b1, '{7'h00, 7'h3F, 7'h7F, 7'h21}};
    vecs[2] = '{4'b1001, 1'b1, 1'b0, '{7'h0E, 7'h40, 7'h7F, 7'h08}};
    vecs[3] = '{4'b0111, 1'b0, 1'b1, '{7'h78, 7'h7F, 7'h7F, 7'h21}};
    vecs[4] = '{4'b1011, 1'b0, 1'b0, '{7'h12, 7'h3F, 7'h7F, 7'h08}};
    vecs[5] = '{4'b0000, 1'b0, 1'b1, '{7'h40, 7'h7F, 7'h7F, 7'h21}};
    vecs[6] = '{4'b1010, 1'b0, 1'b1, '{7'h02, 7'h3F, 7'h7F, 7'h21}};
    vecs[7] = '{4'b0001, 1'b0, 1'b0, '{7'h79, 7'h7F, 7'h7F, 7'h08}};

    rst_n = 1'b0;
    bus_if.load = 1'b0;
    bus_if.sum  = 4'd0;
    bus_if.ovf  = 1'b0;
    bus_if.sel  = 1'b0;
    repeat (3) @(negedge clk);
    check_pins("reset");
    rst_n = 1'b1;

    // Nothing loaded yet: display stays dark
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check_pins("idle");
    end

    for (int i = 0; i < 8; i++) load_and_scan(vecs[i], $sformatf("vec%0d", i));

    // Mid-slot reload: 1 -> -1 keeps the idx0 glyph, adds '-' on idx1
    wait_slot(0, 1, "midload");
    check_pins("midload_pre");
    bus_if.load = 1'b1;
    bus_if.sum  = 4'b1111;
    @(negedge clk);
    check_pins("midload_edge");
    bus_if.load = 1'b0;
    cur_exp[1] = 7'h3F;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check_pins("midload");
    end

    // Reset in the idx2 slot with load asserted at the same edge
    wait_slot(2, 1, "rstmid");
    rst_n = 1'b0;
    bus_if.load = 1'b1;
    bus_if.sum  = 4'b0101;
    bus_if.sel  = 1'b1;
    @(negedge clk);
    exp_valid = 1'b0;
    check_pins("rst_edge");
    rst_n = 1'b1;
    bus_if.load = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_pins("post_rst");
    end
    load_and_scan('{4'b1110, 1'b0, 1'b1, '{7'h24, 7'h3F, 7'h7F, 7'h21}}, "reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
